// File: rtl/pipe_exec_ctrl_if.sv
// Control/status bundle between the pipeline execution sequencer and the
// switch panel / pipeline datapath. The sequencer takes the slave side.
interface pipe_exec_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             step_sw;
    logic             run_sw;
    logic             bp_en;
    logic [31:0]      bp_addr;
    logic [31:0]      if_pc;
    logic             regwrite;
    logic             adv_en;
    logic [1:0]       state;
    logic [CNT_W-1:0] cycle_count;
    logic [CNT_W-1:0] retired_count;
    logic             led;

    modport master (
        output step_sw, run_sw, bp_en, bp_addr, if_pc, regwrite,
        input  adv_en, state, cycle_count, retired_count, led
    );

    modport slave (
        input  step_sw, run_sw, bp_en, bp_addr, if_pc, regwrite,
        output adv_en, state, cycle_count, retired_count, led
    );
endinterface

// File: rtl/pipe_exec_ctrl.sv
// Pipeline execution sequencer: debounced step/run, divided free-run, PC breakpoint with drain.
// Optional step auto-repeat in IDLE is compiled in with `define PEC_AUTOREPEAT_EN.
//
//   state | meaning
//   IDLE  | waiting; one adv_en per debounced step press
//   RUN   | adv_en every RUN_DIV clocks, breakpoint armed
//   DRAIN | DRAIN_CYCLES back-to-back adv_en to flush older instructions
//   HALT  | stopped at breakpoint until run switch is lowered
module pipe_exec_ctrl #(
    parameter int DEBOUNCE_CYCLES = 600000,
    parameter int DB_W            = 21,
    parameter int RUN_DIV         = 1,
    parameter int DRAIN_CYCLES    = 4,
    parameter int CNT_W           = 32
) (
    input logic             clk,
    input logic             reset,
    pipe_exec_ctrl_if.slave bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    localparam int DIV_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
    localparam int DRN_W = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

    localparam logic [DB_W-1:0]  DB_TC      = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(RUN_DIV - 1);
    localparam logic [DRN_W-1:0] DRN_LOAD   = DRN_W'(DRAIN_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    logic              r_step_cand, r_step_db, r_step_db_d;
    logic [DB_W-1:0]   r_step_cnt;
    logic              r_run_cand, r_run_db;
    logic [DB_W-1:0]   r_run_cnt;

    logic [1:0]        r_state;
    logic              r_adv_en;
    logic [DIV_W-1:0]  r_div;
    logic [DRN_W-1:0]  r_drain;
    logic [CNT_W-1:0]  r_cycle_count;
    logic [CNT_W-1:0]  r_retired_count;
    logic              r_led;

    logic              w_step_rise;
    logic              w_step_pulse;
    logic [1:0]        w_state_nxt;
    logic              w_adv_nxt;
    logic [DIV_W-1:0]  w_div_nxt;
    logic [DRN_W-1:0]  w_drain_nxt;
    logic              w_bp_hit;

    // Reset loads the raw levels so a switch held through reset gives no edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_step_cand <= bus.step_sw;
            r_step_db   <= bus.step_sw;
            r_step_db_d <= bus.step_sw;
            r_step_cnt  <= '0;
        end else begin
            r_step_db_d <= r_step_db;
            if (bus.step_sw != r_step_cand) begin
                r_step_cand <= bus.step_sw;
                r_step_cnt  <= '0;
            end else if (r_step_cnt == DB_TC) begin
                r_step_db <= r_step_cand;
            end else begin
                r_step_cnt <= r_step_cnt + DB_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_run_cand <= bus.run_sw;
            r_run_db   <= bus.run_sw;
            r_run_cnt  <= '0;
        end else if (bus.run_sw != r_run_cand) begin
            r_run_cand <= bus.run_sw;
            r_run_cnt  <= '0;
        end else if (r_run_cnt == DB_TC) begin
            r_run_db <= r_run_cand;
        end else begin
            r_run_cnt <= r_run_cnt + DB_W'(1);
        end
    end

    assign w_step_rise = r_step_db & ~r_step_db_d;

`ifdef PEC_AUTOREPEAT_EN
    localparam int REP_W = $clog2(16 * DEBOUNCE_CYCLES + 1);
    localparam logic [REP_W-1:0] REP_FIRST = REP_W'(16 * DEBOUNCE_CYCLES - 1);
    localparam logic [REP_W-1:0] REP_NEXT  = REP_W'(4 * DEBOUNCE_CYCLES - 1);

    logic [REP_W-1:0] r_rep_cnt;
    logic             r_rep_act;
    logic             w_rep_arm;
    logic             w_rep_fire;

    // Repeat only while the press that started it is still held in IDLE.
    assign w_rep_arm  = (r_state == S_IDLE) && !r_run_db && r_step_db;
    assign w_rep_fire = w_rep_arm && r_rep_act && !w_step_rise && (r_rep_cnt == '0);

    always_ff @(posedge clk) begin
        if (reset || !w_rep_arm) begin
            r_rep_cnt <= '0;
            r_rep_act <= 1'b0;
        end else if (w_step_rise) begin
            r_rep_cnt <= REP_FIRST;
            r_rep_act <= 1'b1;
        end else if (r_rep_act) begin
            r_rep_cnt <= (r_rep_cnt == '0) ? REP_NEXT : r_rep_cnt - REP_W'(1);
        end
    end

    assign w_step_pulse = w_step_rise | w_rep_fire;
`else
    assign w_step_pulse = w_step_rise;
`endif

    assign w_bp_hit = bus.bp_en && r_adv_en && (bus.if_pc == bus.bp_addr);

    always_comb begin
        w_state_nxt = r_state;
        w_adv_nxt   = 1'b0;
        w_div_nxt   = r_div;
        w_drain_nxt = r_drain;
        case (r_state)
            S_IDLE: begin
                if (r_run_db) begin
                    w_state_nxt = S_RUN;
                    w_div_nxt   = '0;
                end else if (w_step_pulse) begin
                    w_adv_nxt = 1'b1;
                end
            end
            S_RUN: begin
                if (!r_run_db) begin
                    w_state_nxt = S_IDLE;
                    w_div_nxt   = '0;
                end else if (w_bp_hit) begin
                    w_state_nxt = S_DRAIN;
                    w_drain_nxt = DRN_LOAD;
                end else if (r_div == '0) begin
                    w_adv_nxt = 1'b1;
                    w_div_nxt = DIV_RELOAD;
                end else begin
                    w_div_nxt = r_div - DIV_W'(1);
                end
            end
            S_DRAIN: begin
                if (r_drain != '0) begin
                    w_adv_nxt   = 1'b1;
                    w_drain_nxt = r_drain - DRN_W'(1);
                end else begin
                    w_state_nxt = S_HALT;
                end
            end
            S_HALT: begin
                if (!r_run_db) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_adv_en <= 1'b0;
            r_div    <= '0;
            r_drain  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_adv_en <= w_adv_nxt;
            r_div    <= w_div_nxt;
            r_drain  <= w_drain_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cycle_count   <= '0;
            r_retired_count <= '0;
            r_led           <= 1'b0;
        end else if (r_adv_en) begin
            if (r_cycle_count != CNT_MAX) begin
                r_cycle_count <= r_cycle_count + CNT_W'(1);
            end
            if (bus.regwrite) begin
                if (r_retired_count != CNT_MAX) begin
                    r_retired_count <= r_retired_count + CNT_W'(1);
                end
                r_led <= ~r_led;
            end
        end
    end

    assign bus.adv_en        = r_adv_en;
    assign bus.state         = r_state;
    assign bus.cycle_count   = r_cycle_count;
    assign bus.retired_count = r_retired_count;
    assign bus.led           = r_led;

endmodule

// File: tb/tb_pipe_exec_ctrl.sv
// Randomized bench for pipe_exec_ctrl: two instances (RUN_DIV=1 and 3) checked every
// cycle against a run-length/phase based reference model, plus directed scenario checks.
module tb_pipe_exec_ctrl;

    localparam int DB    = 3;
    localparam int DRAIN = 4;
    localparam logic [63:0] CNT_MAX = 64'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        step_sw = 1'b1;
    logic        run_sw = 1'b0;
    logic        bp_en = 1'b0;
    logic [31:0] bp_addr = 32'h0;
    logic [31:0] if_pc = 32'h0;
    logic        regwrite = 1'b0;

    always #5 clk = ~clk;

    pipe_exec_ctrl_if #(.CNT_W(32)) if_a ();
    pipe_exec_ctrl_if #(.CNT_W(32)) if_b ();

    assign if_a.step_sw = step_sw;   assign if_b.step_sw = step_sw;
    assign if_a.run_sw = run_sw;     assign if_b.run_sw = run_sw;
    assign if_a.bp_en = bp_en;       assign if_b.bp_en = bp_en;
    assign if_a.bp_addr = bp_addr;   assign if_b.bp_addr = bp_addr;
    assign if_a.if_pc = if_pc;       assign if_b.if_pc = if_pc;
    assign if_a.regwrite = regwrite; assign if_b.regwrite = regwrite;

    pipe_exec_ctrl #(.DEBOUNCE_CYCLES(DB), .DB_W(21), .RUN_DIV(1), .DRAIN_CYCLES(DRAIN), .CNT_W(32))
        u_dut_a (.clk(clk), .reset(reset), .bus(if_a.slave));
    pipe_exec_ctrl #(.DEBOUNCE_CYCLES(DB), .DB_W(21), .RUN_DIV(3), .DRAIN_CYCLES(DRAIN), .CNT_W(32))
        u_dut_b (.clk(clk), .reset(reset), .bus(if_b.slave));

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: debounce as "raw level unchanged for DB+2 samples",
    // RUN cadence as cycles-since-entry modulo the divider.
    int          divs [2] = '{1, 3};
    int          m_st [2];
    bit          m_adv [2];
    logic [63:0] m_cyc [2];
    logic [63:0] m_ret [2];
    bit          m_led [2];
    int          m_phase [2];
    int          m_drain [2];
    bit          db_step, db_step_prev, db_run, last_step, last_run;
    int          len_step, len_run;

    task automatic model_edge();
        bit rise;
        bit nxt;
        bit adv_now;
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                m_st[i] = 0; m_adv[i] = 0; m_cyc[i] = 0; m_ret[i] = 0;
                m_led[i] = 0; m_phase[i] = 0; m_drain[i] = 0;
            end
            db_step = step_sw; db_step_prev = step_sw; last_step = step_sw; len_step = 1;
            db_run = run_sw; last_run = run_sw; len_run = 1;
            return;
        end
        rise = db_step && !db_step_prev;
        for (int i = 0; i < 2; i++) begin
            adv_now = m_adv[i];
            nxt = 1'b0;
            if (adv_now) begin
                if (m_cyc[i] != CNT_MAX) m_cyc[i] = m_cyc[i] + 1;
                if (regwrite) begin
                    if (m_ret[i] != CNT_MAX) m_ret[i] = m_ret[i] + 1;
                    m_led[i] = !m_led[i];
                end
            end
            case (m_st[i])
                0: if (db_run) begin m_st[i] = 1; m_phase[i] = 0; end
                   else if (rise) nxt = 1'b1;
                1: if (!db_run) m_st[i] = 0;
                   else if (bp_en && adv_now && if_pc == bp_addr) begin
                       m_st[i] = 2; m_drain[i] = DRAIN;
                   end else begin
                       nxt = ((m_phase[i] % divs[i]) == 0);
                       m_phase[i]++;
                   end
                2: if (m_drain[i] > 0) begin nxt = 1'b1; m_drain[i]--; end
                   else m_st[i] = 3;
                default: if (!db_run) m_st[i] = 0;
            endcase
            m_adv[i] = nxt;
        end
        db_step_prev = db_step;
        len_step = (step_sw == last_step) ? len_step + 1 : 1;
        last_step = step_sw;
        if (len_step >= DB + 2) begin db_step = step_sw; len_step = DB + 2; end
        len_run = (run_sw == last_run) ? len_run + 1 : 1;
        last_run = run_sw;
        if (len_run >= DB + 2) begin db_run = run_sw; len_run = DB + 2; end
    endtask

    task automatic check_outputs();
        check_val("a_adv",  64'(if_a.adv_en),        64'(m_adv[0]));
        check_val("a_st",   64'(if_a.state),         64'(m_st[0]));
        check_val("a_cyc",  64'(if_a.cycle_count),   m_cyc[0]);
        check_val("a_ret",  64'(if_a.retired_count), m_ret[0]);
        check_val("a_led",  64'(if_a.led),           64'(m_led[0]));
        check_val("b_adv",  64'(if_b.adv_en),        64'(m_adv[1]));
        check_val("b_st",   64'(if_b.state),         64'(m_st[1]));
        check_val("b_cyc",  64'(if_b.cycle_count),   m_cyc[1]);
        check_val("b_ret",  64'(if_b.retired_count), m_ret[1]);
        check_val("b_led",  64'(if_b.led),           64'(m_led[1]));
    endtask

    int          n_pulse_a = 0;
    bit          pc_adv_prev = 0;
    logic [31:0] pc_mask = 32'hFFFF_FFFF;
    int          rw_mode = 0;
    logic [7:0]  rw_pat = 8'b0110_1101;
    int          rw_idx = 0;

    // Inputs only change at the falling edge; the pc advances after each pulse retires.
    task automatic cyc(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            check_outputs();
            if (if_a.adv_en === 1'b1) n_pulse_a++;
            if (pc_adv_prev) if_pc = (if_pc + 32'd4) & pc_mask;
            pc_adv_prev = m_adv[0];
            case (rw_mode)
                1: begin
                    regwrite = m_adv[0] && (rw_idx < 8) && rw_pat[rw_idx];
                    if (m_adv[0]) rw_idx++;
                end
                2: regwrite = 1'($urandom_range(0, 1));
                default: regwrite = 1'b0;
            endcase
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        if_pc = 32'h0;
        pc_adv_prev = 0;
    endtask

    int q_rel [$];
    int rel;

    initial begin
        #5_000_000;
        $display("FAIL timeout sim_time got=%0t exp=<5ms", $time);
        $fatal(1, "timeout");
    end

    initial begin
        // Reset with step held: no pulse after release.
        cyc(3);
        reset = 1'b0;
        n_pulse_a = 0;
        cyc(12);
        check_val("p1_pulses", 64'(n_pulse_a), 0);
        check_val("p1_state", 64'(if_a.state), 0);
        check_val("p1_cyc", 64'(if_a.cycle_count), 0);
        check_val("p1_led", 64'(if_a.led), 0);

        // Bounce then stable press -> exactly one pulse.
        step_sw = 1'b0;
        cyc(10);
        n_pulse_a = 0;
        for (int k = 0; k < 4; k++) begin
            step_sw = (k % 2 == 0);
            cyc(2);
        end
        step_sw = 1'b1;
        cyc(10);
        check_val("p2_one_pulse", 64'(n_pulse_a), 1);
        check_val("p2_cyc", 64'(if_a.cycle_count), 1);
        step_sw = 1'b0;
        cyc(10);
        n_pulse_a = 0;
        step_sw = 1'b1;
        cyc(3);
        step_sw = 1'b0;
        cyc(10);
        check_val("p2_short_bounce", 64'(n_pulse_a), 0);

        // Free run, no breakpoint.
        do_reset();
        n_pulse_a = 0;
        run_sw = 1'b1;
        for (int k = 0; k < 60 && n_pulse_a < 20; k++) cyc(1);
        cyc(1);
        check_val("p3_state", 64'(if_a.state), 1);
        check_val("p3_cyc20", 64'(if_a.cycle_count), 20);
        check_val("p3_adv_cont", 64'(if_a.adv_en), 1);
        run_sw = 1'b0;
        cyc(8);
        check_val("p3_idle", 64'(if_a.state), 0);
        check_val("p3_adv_off", 64'(if_a.adv_en), 0);

        // Breakpoint at 0xC with drain.
        do_reset();
        bp_en = 1'b1;
        bp_addr = 32'h0000_000C;
        run_sw = 1'b1;
        for (int k = 0; k < 60 && if_a.state != 2'd3; k++) cyc(1);
        check_val("p4_halt", 64'(if_a.state), 3);
        check_val("p4_cyc8", 64'(if_a.cycle_count), 8);
        check_val("p4_adv0", 64'(if_a.adv_en), 0);
        cyc(10);
        check_val("p4_hold_halt", 64'(if_a.state), 3);
        check_val("p4_hold_cyc", 64'(if_a.cycle_count), 8);
        run_sw = 1'b0;
        cyc(8);
        check_val("p4_release", 64'(if_a.state), 0);

        // Divided run: pulses at 1,4,7 after entry; step presses ignored.
        bp_en = 1'b0;
        do_reset();
        run_sw = 1'b1;
        step_sw = 1'b1;
        rel = -1;
        q_rel.delete();
        for (int k = 0; k < 60 && q_rel.size() < 3; k++) begin
            cyc(1);
            if (rel >= 0) rel++;
            else if (if_b.state == 2'd1) rel = 0;
            if (rel >= 0 && if_b.adv_en === 1'b1) q_rel.push_back(rel);
            if (rel == 2) step_sw = 1'b0;
        end
        check_val("p5_npulse", 64'(q_rel.size()), 3);
        if (q_rel.size() == 3) begin
            check_val("p5_off0", 64'(q_rel[0]), 1);
            check_val("p5_off1", 64'(q_rel[1]), 4);
            check_val("p5_off2", 64'(q_rel[2]), 7);
        end
        step_sw = 1'b1;
        cyc(12);
        step_sw = 1'b0;
        run_sw = 1'b0;
        cyc(10);

        // Retirement counting on 5 of 8 pulses, then reset mid-drain.
        do_reset();
        rw_mode = 1;
        rw_idx = 0;
        bp_en = 1'b1;
        bp_addr = 32'h0000_000C;
        run_sw = 1'b1;
        for (int k = 0; k < 60 && if_a.state != 2'd3; k++) cyc(1);
        check_val("p6_cyc8", 64'(if_a.cycle_count), 8);
        check_val("p6_ret5", 64'(if_a.retired_count), 5);
        check_val("p6_led", 64'(if_a.led), 1);
        rw_mode = 2;
        run_sw = 1'b0;
        cyc(8);
        if_pc = 32'h0;
        pc_adv_prev = 0;
        run_sw = 1'b1;
        for (int k = 0; k < 60 && if_a.state != 2'd2; k++) cyc(1);
        check_val("p6_in_drain", 64'(if_a.state), 2);
        reset = 1'b1;
        cyc(1);
        check_val("p6_rst_state", 64'(if_a.state), 0);
        check_val("p6_rst_cyc", 64'(if_a.cycle_count), 0);
        check_val("p6_rst_ret", 64'(if_a.retired_count), 0);
        check_val("p6_rst_adv", 64'(if_a.adv_en), 0);
        reset = 1'b0;
        run_sw = 1'b0;
        if_pc = 32'h0;
        pc_adv_prev = 0;
        cyc(8);

        // Random switch activity, breakpoints and occasional resets.
        pc_mask = 32'h0000_001F;
        for (int k = 0; k < 400; k++) begin
            case ($urandom_range(0, 5))
                0, 1: run_sw = ~run_sw;
                2, 3: step_sw = ~step_sw;
                4: bp_en = ~bp_en;
                default: bp_addr = 32'($urandom_range(0, 7)) << 2;
            endcase
            if ($urandom_range(0, 50) == 0) begin
                reset = 1'b1;
                cyc(1);
                reset = 1'b0;
            end
            cyc($urandom_range(1, 12));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_exec_ctrl.md
Name: pipe_exec_ctrl

Overview:
Execution sequencer for the 5-stage MIPS pipeline. It debounces the step and run switches and issues a one-cycle advance enable, adv_en, to every stage register (fetch, decode, execute, memory, writeback). This replaces the free-running debounced pseudo-clock.
- Modes: single-step, free-run at a divided rate, and PC breakpoint with pipeline drain.
- Status: advance/retire counters and a writeback-activity LED.

Parameters:
DEBOUNCE_CYCLES, 600000, stable-sample count required before a debounced switch level changes
DB_W, 21, width of each debounce counter (must hold DEBOUNCE_CYCLES)
RUN_DIV, 1, clocks per adv_en pulse in RUN (>=1)
DRAIN_CYCLES, 4, adv_en pulses issued after a breakpoint hit so older instructions reach WB
CNT_W, 32, width of cycle_count and retired_count

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
step_sw  in  1  raw step switch/button
run_sw  in  1  raw run switch (level)
bp_en  in  1  breakpoint enable
bp_addr  in  32  breakpoint PC
if_pc  in  32  PC of the instruction currently being fetched
regwrite  in  1  writeback-stage RegWrite
adv_en  out  1  registered advance enable for all pipeline registers
state  out  2  0=IDLE 1=RUN 2=DRAIN 3=HALT
cycle_count  out  CNT_W  total adv_en pulses issued
retired_count  out  CNT_W  adv_en cycles with regwrite=1
led  out  1  toggles on each retired register write

Behaviour:
- Clock and reset: clock clk; reset reset, synchronous, active-high.
- Reset values: state=IDLE, adv_en=0, cycle_count=0, retired_count=0, led=0, all debounce counters=0.
  - Debounced and candidate levels load the current raw switch values, so no spurious edge follows reset.
  - Reset mid-RUN or mid-DRAIN aborts on that edge.
- Debounce, identical per switch. Each clock:
  - If raw != cand: cand<=raw, cnt<=0.
  - Else if cnt==DEBOUNCE_CYCLES: db<=cand.
  - Else: cnt<=cnt+1.
- step_rise = db_step & ~db_step_d (one-cycle, registered previous value).
- adv_en is registered: a decision in cycle t drives adv_en=1 in cycle t+1 only, high for exactly one cycle per decision.
- IDLE:
  - db_run=1 -> RUN, divider cleared.
  - Else step_rise -> one adv_en pulse, stay IDLE.
  - db_run and step_rise together: RUN wins, and that step is dropped.
- RUN:
  - adv_en pulses once every RUN_DIV clocks; the first pulse is in the first cycle after entry.
  - db_run=0 -> IDLE immediately, no drain; any pending divider count is discarded.
  - bp_en=1 and adv_en=1 and if_pc==bp_addr -> DRAIN. The breakpoint instruction is the last one fetched.
  - step_rise is ignored.
- DRAIN:
  - Issues exactly DRAIN_CYCLES pulses, one per clock, ignoring RUN_DIV.
  - db_run and step are ignored.
  - Moves to HALT after the last pulse; adv_en=0 from the first HALT cycle.
- HALT:
  - No pulses; step is ignored.
  - db_run=0 -> IDLE. A new run requires run_sw to be lowered and raised again.
- Breakpoint match is checked only in RUN. A breakpoint at the current PC when RUN is entered fires on the first pulse.
- cycle_count increments on each adv_en=1 cycle and saturates at all-ones.
- retired_count increments, and led toggles, on cycles with adv_en=1 and regwrite=1. retired_count saturates; led keeps toggling.
- All outputs are registers; there are no combinational input-to-output paths.

Optional Feature:
Macro PEC_AUTOREPEAT_EN.
- Defined: in IDLE, holding db_step=1 issues one pulse on step_rise. After 16*DEBOUNCE_CYCLES further held clocks, it issues one more pulse every 4*DEBOUNCE_CYCLES clocks until db_step=0. The repeat counter clears on release, state change, or reset.
- Undefined: exactly one pulse per step_rise, and no repeat counter logic exists.

Test Plan:
1. Bench parameters: DEBOUNCE_CYCLES=3, RUN_DIV=1, DRAIN_CYCLES=4.
   - Reset with step_sw=1 held, release reset -> no adv_en pulse, state=0, counters 0, led=0.
2. Bounce step_sw 0/1 for 2-cycle intervals, then hold 1 for 10 cycles -> exactly one adv_en pulse, cycle_count=1.
   - Bounce shorter than 4 stable samples -> zero pulses.
3. Set run_sw=1, bp_en=0 -> state=1 and adv_en=1 every cycle; after 20 pulses cycle_count=20.
   - Drop run_sw -> state=0 and adv_en=0 once db_run falls.
4. bp_en=1, bp_addr=0x0000000C, if_pc advancing 0,4,8,C on each pulse, run_sw=1:
   - Pulse with if_pc=0xC -> state=2.
   - Exactly 4 further pulses, then state=3 and adv_en=0.
   - cycle_count=8; run_sw held high stays in HALT; lowering it -> state=0.
5. RUN_DIV=3 run -> adv_en on cycles 1,4,7 after RUN entry. Step_rise during RUN -> no extra pulse.
6. regwrite=1 on 5 of 8 pulses -> retired_count=5, led=1. Reset asserted mid-DRAIN -> state=0 and all counters 0 on the next edge.
